router_ctrl: RTL and testbench
==============================

ROUTER_CTRL -- requirements
Module: router_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: resetn  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: pkt_valid  input  1  source is driving packet bytes; deasserts on the parity byte.
REQ-004 SHALL have port: data_in  input  2  destination address, valid with pkt_valid in DECODE_ADDRESS.
REQ-005 SHALL have port: fifo_full  input  3  full flag of FIFO 0..2.
REQ-006 SHALL have port: fifo_empty  input  3  empty flag of FIFO 0..2.
REQ-007 SHALL have port: read_enb  input  3  per-FIFO read strobe from the output side.
REQ-008 SHALL have port: parity_done  input  1  register block has captured the parity byte.
REQ-009 SHALL have port: low_pkt_valid  input  1  pkt_valid fell while the FIFO was full.
REQ-010 SHALL have port: write_enb  output  3  one-hot FIFO write enable.
REQ-011 SHALL have port: soft_reset  output  3  per-FIFO one-cycle timeout flush pulse.
REQ-012 SHALL have port: vld_out  output  3  per-FIFO data-available indication.
REQ-013 SHALL have ports: detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy  output  1 each  state decodes for the register block and source.

Function
REQ-014 SHALL implement an 8-state FSM: DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR.
REQ-015 DECODE_ADDRESS: pkt_valid and data_in!=3 -> latch data_in into sel; next LOAD_FIRST_DATA if fifo_empty[data_in], else WAIT_TILL_EMPTY; data_in==3 or !pkt_valid -> stay, nothing latched.
REQ-016 WAIT_TILL_EMPTY: fifo_empty[sel] -> LOAD_FIRST_DATA; else stay.
REQ-017 LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
REQ-018 LOAD_DATA: fifo_full[sel] -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay; full has priority.
REQ-019 FIFO_FULL_STATE: !fifo_full[sel] -> LOAD_AFTER_FULL; else stay.
REQ-020 LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else LOAD_DATA.
REQ-021 LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
REQ-022 CHECK_PARITY_ERROR: fifo_full[sel] -> FIFO_FULL_STATE; else DECODE_ADDRESS.
REQ-023 soft_reset[sel] high in any state SHALL force DECODE_ADDRESS next cycle, overriding REQ-015..022.
REQ-024 Decodes SHALL be combinational from state only: detect_add=DECODE_ADDRESS, lfd_state=LOAD_FIRST_DATA, ld_state=LOAD_DATA, laf_state=LOAD_AFTER_FULL, full_state=FIFO_FULL_STATE, rst_int_reg=CHECK_PARITY_ERROR.
REQ-025 busy SHALL be 1 in every state except DECODE_ADDRESS and LOAD_DATA.
REQ-026 write_enb[sel] SHALL be 1 in LOAD_FIRST_DATA, LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY; other bits always 0; never more than one bit set.
REQ-027 vld_out[i] SHALL equal ~fifo_empty[i], combinational.
REQ-028 Each FIFO i SHALL have a 5-bit timeout counter: vld_out[i]&&!read_enb[i] -> increment; otherwise -> clear to 0.
REQ-029 When counter i equals 29 and still counting, soft_reset[i] SHALL be 1 for the next cycle only, and counter i SHALL clear; i.e. pulse after 30 consecutive unread valid cycles.
REQ-030 read_enb[i] on the 30th cycle SHALL suppress the pulse; the counter SHALL never exceed 29.
REQ-031 The three timeouts SHALL run independently; simultaneous pulses allowed.

Reset
REQ-032 resetn low SHALL asynchronously set state=DECODE_ADDRESS, sel=0, all timeout counters=0, soft_reset=3'b000.
REQ-033 During and right after reset: detect_add=1, busy=0, write_enb=3'b000, other decodes 0; vld_out follows fifo_empty.
REQ-034 Reset asserted mid-packet SHALL abort the packet; no write_enb pulse in the cycle after resetn rises.

Verification
REQ-035 FIFOs empty, pkt_valid=1, data_in=2, 4 payload bytes, then pkt_valid=0 -> states DECODE, LFD, LD x4, LOAD_PARITY, CHECK_PARITY, DECODE; write_enb=3'b100 for 6 cycles.
REQ-036 fifo_empty[1]=0, header addr 1 -> WAIT_TILL_EMPTY, busy=1, write_enb=0 until fifo_empty[1]=1, then LOAD_FIRST_DATA next cycle.
REQ-037 fifo_full[0] rises in LOAD_DATA -> FIFO_FULL_STATE, write_enb=0; full falls -> LOAD_AFTER_FULL; parity_done=0, low_pkt_valid=1 -> LOAD_PARITY.
REQ-038 fifo_empty[1]=0, read_enb[1]=0 for 30 cycles -> soft_reset[1]=1 one cycle; repeat with read_enb[1] pulsed on cycle 30 -> no pulse.
REQ-039 Header data_in=3 with pkt_valid=1 -> stays DECODE_ADDRESS, write_enb=0; resetn pulsed low in LOAD_DATA -> immediate DECODE_ADDRESS, counters 0.

Source files
------------

// File: rtl/router_ctrl_if.sv
// Signal bundle between the router controller and the source / FIFO / register-block side.
// The slave modport is the controller's view; the master modport is the surrounding logic's view.
interface router_ctrl_if;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic       parity_done;
  logic       low_pkt_valid;
  logic [2:0] write_enb;
  logic [2:0] soft_reset;
  logic [2:0] vld_out;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic       busy;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, read_enb, parity_done, low_pkt_valid,
    input  write_enb, soft_reset, vld_out, detect_add, lfd_state, ld_state, laf_state,
           full_state, rst_int_reg, busy
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, read_enb, parity_done, low_pkt_valid,
    output write_enb, soft_reset, vld_out, detect_add, lfd_state, ld_state, laf_state,
           full_state, rst_int_reg, busy
  );
endinterface

// File: rtl/router_ctrl.sv
// Router packet-flow controller: steers one packet at a time into one of three FIFOs
// and flushes any FIFO whose data sits unread for 30 consecutive cycles.
module router_ctrl (
  input logic          clk,
  input logic          resetn,
  router_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    WAIT_TILL_EMPTY,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR
  } state_e;

  localparam logic [4:0] TIMEOUT_LAST = 5'd29;

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [4:0] cnt_q [0:2];
  logic [4:0] cnt_d [0:2];
  logic [2:0] soft_reset_q, soft_reset_d;
  logic [2:0] sel_oh;
  logic [2:0] din_oh;
  logic [2:0] vld;

  // One-hot forms avoid indexing the 3-bit flags with a 2-bit value that could read 3.
  assign sel_oh = 3'b001 << sel_q;
  assign din_oh = 3'b001 << bus.data_in;
  assign vld    = ~bus.fifo_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= DECODE_ADDRESS;
      sel_q        <= 2'd0;
      soft_reset_q <= 3'b000;
      for (int i = 0; i < 3; i++) cnt_q[i] <= 5'd0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      soft_reset_q <= soft_reset_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    soft_reset_d = 3'b000;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = 5'd0;
      if (vld[i] && !bus.read_enb[i]) begin
        if (cnt_q[i] == TIMEOUT_LAST) soft_reset_d[i] = 1'b1;
        else                          cnt_d[i] = cnt_q[i] + 5'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (|(soft_reset_q & sel_oh)) begin
      state_d = DECODE_ADDRESS;
    end else begin
      unique case (state_q)
        DECODE_ADDRESS: begin
          if (bus.pkt_valid && bus.data_in != 2'd3) begin
            sel_d   = bus.data_in;
            state_d = (|(bus.fifo_empty & din_oh)) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        WAIT_TILL_EMPTY:
          if (|(bus.fifo_empty & sel_oh)) state_d = LOAD_FIRST_DATA;
        LOAD_FIRST_DATA:
          state_d = LOAD_DATA;
        LOAD_DATA: begin
          if (|(bus.fifo_full & sel_oh)) state_d = FIFO_FULL_STATE;
          else if (!bus.pkt_valid)       state_d = LOAD_PARITY;
        end
        FIFO_FULL_STATE:
          if (!(|(bus.fifo_full & sel_oh))) state_d = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL: begin
          if (bus.parity_done)        state_d = DECODE_ADDRESS;
          else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
          else                        state_d = LOAD_DATA;
        end
        LOAD_PARITY:
          state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          state_d = (|(bus.fifo_full & sel_oh)) ? FIFO_FULL_STATE : DECODE_ADDRESS;
        default:
          state_d = DECODE_ADDRESS;
      endcase
    end
  end

  always_comb begin
    bus.detect_add  = (state_q == DECODE_ADDRESS);
    bus.lfd_state   = (state_q == LOAD_FIRST_DATA);
    bus.ld_state    = (state_q == LOAD_DATA);
    bus.laf_state   = (state_q == LOAD_AFTER_FULL);
    bus.full_state  = (state_q == FIFO_FULL_STATE);
    bus.rst_int_reg = (state_q == CHECK_PARITY_ERROR);
    bus.busy        = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
    bus.write_enb   = 3'b000;
    if (state_q == LOAD_FIRST_DATA || state_q == LOAD_DATA ||
        state_q == LOAD_AFTER_FULL || state_q == LOAD_PARITY)
      bus.write_enb = sel_oh;
  end

  assign bus.vld_out    = vld;
  assign bus.soft_reset = soft_reset_q;

endmodule

// File: tb/tb_router_ctrl.sv
// Directed bench for router_ctrl: a vector table for the packet FSM plus hand-written
// sequences for the timeout flush, soft-reset abort and asynchronous reset.
module tb_router_ctrl;
  logic clk = 1'b0;
  logic resetn;
  int   n_chk = 0;
  int   n_fail = 0;

  router_ctrl_if bus ();
  router_ctrl dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  // Decode vector: {detect_add, lfd, ld, laf, full, rst_int_reg, busy}
  localparam logic [6:0] DA  = 7'b1000000;
  localparam logic [6:0] WTE = 7'b0000001;
  localparam logic [6:0] LFD = 7'b0100001;
  localparam logic [6:0] LD  = 7'b0010000;
  localparam logic [6:0] LAF = 7'b0001001;
  localparam logic [6:0] FUL = 7'b0000101;
  localparam logic [6:0] LP  = 7'b0000001;
  localparam logic [6:0] CPE = 7'b0000011;

  typedef struct {
    logic       pv;
    logic [1:0] din;
    logic [2:0] full;
    logic [2:0] empty;
    logic       pd;
    logic       lpv;
    logic [6:0] exp_dec;
    logic [2:0] exp_we;
    logic [2:0] exp_vld;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [6:0] dec();
    return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
            bus.full_state, bus.rst_int_reg, bus.busy};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic pv, input logic [1:0] din, input logic [2:0] full,
                     input logic [2:0] empty, input logic pd, input logic lpv,
                     input logic [6:0] d, input logic [2:0] we, input logic [2:0] v);
    vec_t x;
    x.pv = pv; x.din = din; x.full = full; x.empty = empty; x.pd = pd; x.lpv = lpv;
    x.exp_dec = d; x.exp_we = we; x.exp_vld = v;
    vecs.push_back(x);
  endtask

  initial begin
    // Header address 3 is ignored, then idle
    add(1, 3, 0, 3'b111, 0, 0, DA,  3'b000, 3'b000);
    add(1, 3, 0, 3'b111, 0, 0, DA,  3'b000, 3'b000);
    add(0, 1, 0, 3'b111, 0, 0, DA,  3'b000, 3'b000);
    // Packet to FIFO 2 with four payload bytes
    add(1, 2, 0, 3'b111, 0, 0, DA,  3'b000, 3'b000);
    add(1, 0, 0, 3'b111, 0, 0, LFD, 3'b100, 3'b000);
    add(1, 0, 0, 3'b111, 0, 0, LD,  3'b100, 3'b000);
    add(1, 0, 0, 3'b111, 0, 0, LD,  3'b100, 3'b000);
    add(1, 0, 0, 3'b111, 0, 0, LD,  3'b100, 3'b000);
    add(0, 0, 0, 3'b111, 0, 0, LD,  3'b100, 3'b000);
    add(0, 0, 0, 3'b111, 0, 0, LP,  3'b100, 3'b000);
    add(0, 0, 0, 3'b111, 0, 0, CPE, 3'b000, 3'b000);
    add(0, 0, 0, 3'b111, 0, 0, DA,  3'b000, 3'b000);
    // FIFO 1 not empty: wait, then load once it drains
    add(1, 1, 0, 3'b101, 0, 0, DA,  3'b000, 3'b010);
    add(1, 0, 0, 3'b101, 0, 0, WTE, 3'b000, 3'b010);
    add(1, 0, 0, 3'b101, 0, 0, WTE, 3'b000, 3'b010);
    add(1, 0, 0, 3'b111, 0, 0, WTE, 3'b000, 3'b000);
    add(1, 0, 0, 3'b111, 0, 0, LFD, 3'b010, 3'b000);
    add(0, 0, 0, 3'b111, 0, 0, LD,  3'b010, 3'b000);
    add(0, 0, 0, 3'b111, 0, 0, LP,  3'b010, 3'b000);
    add(0, 0, 0, 3'b111, 0, 0, CPE, 3'b000, 3'b000);
    add(0, 0, 0, 3'b111, 0, 0, DA,  3'b000, 3'b000);
    // FIFO 0 full paths: low_pkt_valid exit, full after parity, resume, parity_done exit
    add(1, 0, 0,      3'b111, 0, 0, DA,  3'b000, 3'b000);
    add(1, 0, 0,      3'b111, 0, 0, LFD, 3'b001, 3'b000);
    add(1, 0, 3'b001, 3'b111, 0, 0, LD,  3'b001, 3'b000);
    add(1, 0, 3'b001, 3'b111, 0, 0, FUL, 3'b000, 3'b000);
    add(1, 0, 0,      3'b111, 0, 0, FUL, 3'b000, 3'b000);
    add(0, 0, 0,      3'b111, 0, 1, LAF, 3'b001, 3'b000);
    add(0, 0, 0,      3'b111, 0, 0, LP,  3'b001, 3'b000);
    add(0, 0, 3'b001, 3'b111, 0, 0, CPE, 3'b000, 3'b000);
    add(0, 0, 3'b001, 3'b111, 0, 0, FUL, 3'b000, 3'b000);
    add(0, 0, 0,      3'b111, 0, 0, FUL, 3'b000, 3'b000);
    add(1, 0, 0,      3'b111, 0, 0, LAF, 3'b001, 3'b000);
    add(1, 0, 0,      3'b111, 0, 0, LD,  3'b001, 3'b000);
    add(0, 0, 3'b001, 3'b111, 0, 0, LD,  3'b001, 3'b000);
    add(0, 0, 0,      3'b111, 0, 0, FUL, 3'b000, 3'b000);
    add(0, 0, 0,      3'b111, 1, 1, LAF, 3'b001, 3'b000);
    add(0, 0, 0,      3'b111, 0, 0, DA,  3'b000, 3'b000);

    bus.pkt_valid = 0; bus.data_in = 0; bus.fifo_full = 0; bus.fifo_empty = 3'b010;
    bus.read_enb = 0; bus.parity_done = 0; bus.low_pkt_valid = 0;
    resetn = 0;
    step(); step();
    chk("reset_dec", dec(), DA);
    chk("reset_we", bus.write_enb, 3'b000);
    chk("reset_sr", bus.soft_reset, 3'b000);
    chk("reset_vld", bus.vld_out, 3'b101);
    bus.fifo_empty = 3'b111;
    resetn = 1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      bus.pkt_valid = vecs[i].pv; bus.data_in = vecs[i].din; bus.fifo_full = vecs[i].full;
      bus.fifo_empty = vecs[i].empty; bus.parity_done = vecs[i].pd;
      bus.low_pkt_valid = vecs[i].lpv;
      #1;
      chk($sformatf("vec%0d_dec", i), dec(), vecs[i].exp_dec);
      chk($sformatf("vec%0d_we", i), bus.write_enb, vecs[i].exp_we);
      chk($sformatf("vec%0d_vld", i), bus.vld_out, vecs[i].exp_vld);
      chk($sformatf("vec%0d_sr", i), bus.soft_reset, 3'b000);
      step();
    end
    bus.pkt_valid = 0; bus.fifo_full = 0; bus.parity_done = 0; bus.low_pkt_valid = 0;
    bus.fifo_empty = 3'b111;

    // Timeout on FIFO 1: pulse after the 30th unread valid cycle, one cycle wide
    bus.fifo_empty = 3'b101;
    for (int k = 1; k <= 29; k++) begin
      step();
      chk($sformatf("to_idle_%0d", k), bus.soft_reset, 3'b000);
    end
    step();
    chk("to_pulse", bus.soft_reset, 3'b010);
    step();
    chk("to_pulse_end", bus.soft_reset, 3'b000);

    // A read on the 30th cycle suppresses the pulse
    bus.fifo_empty = 3'b111;
    step();
    bus.fifo_empty = 3'b101;
    for (int k = 1; k <= 29; k++) step();
    chk("rd_pre", bus.soft_reset, 3'b000);
    bus.read_enb = 3'b010;
    step();
    chk("rd_suppress", bus.soft_reset, 3'b000);
    bus.read_enb = 3'b000;
    step();
    chk("rd_after", bus.soft_reset, 3'b000);
    bus.fifo_empty = 3'b111;
    step();

    // Simultaneous timeouts on FIFOs 0 and 1 abort a packet loading into FIFO 1
    bus.pkt_valid = 1; bus.data_in = 1;
    step();
    chk("sr_lfd", dec(), LFD);
    bus.fifo_empty = 3'b100;
    for (int k = 1; k <= 29; k++) step();
    chk("sr_ld", dec(), LD);
    chk("sr_pre", bus.soft_reset, 3'b000);
    step();
    chk("sr_both", bus.soft_reset, 3'b011);
    chk("sr_still_ld", dec(), LD);
    step();
    chk("sr_abort", dec(), DA);
    chk("sr_end", bus.soft_reset, 3'b000);
    bus.pkt_valid = 0; bus.fifo_empty = 3'b111;
    step();

    // Asynchronous reset mid-packet clears state and the FIFO 0 counter
    bus.pkt_valid = 1; bus.data_in = 0;
    step(); step();
    chk("rst_ld", dec(), LD);
    bus.fifo_empty = 3'b110;
    for (int k = 0; k < 5; k++) step();
    #2 resetn = 0;
    #1;
    chk("rst_async_dec", dec(), DA);
    chk("rst_async_we", bus.write_enb, 3'b000);
    chk("rst_async_vld", bus.vld_out, 3'b001);
    @(negedge clk);
    bus.pkt_valid = 0;
    resetn = 1;
    #1;
    chk("rst_rel_we", bus.write_enb, 3'b000);
    step();
    chk("rst_after_dec", dec(), DA);
    chk("rst_after_we", bus.write_enb, 3'b000);
    for (int k = 2; k <= 29; k++) step();
    chk("rst_cnt_clear", bus.soft_reset, 3'b000);
    step();
    chk("rst_cnt_pulse", bus.soft_reset, 3'b001);
    bus.fifo_empty = 3'b111;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
